// File: rtl/ccd_frame_sequencer_pkg.sv
// Shared types and constants for the CCD frame sequencer: state encoding,
// phase-split helpers and default integration constants.
package ccd_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_PULSE = 3'd4
  } ccd_state_e;

  localparam logic [31:0] HOLD_BASE_DEF = 32'd32836;
  localparam logic [31:0] STEP_DEF      = 32'h5FA4;

  function automatic int half_len(int l);
    return l / 2;
  endfunction

  function automatic int tq_len(int l);
    return (3 * l) / 4;
  endfunction

endpackage

// File: rtl/ccd_frame_sequencer_if.sv
// Config/handshake inputs and waveform/status outputs of the frame sequencer.
interface ccd_frame_sequencer_if #(
  parameter int SHIFT_W     = 12,
  parameter int FSEL_W      = 4,
  parameter int FRAME_CNT_W = 16
);
  logic                   tick_i, enable_i, single_i, start_i;
  logic [FSEL_W-1:0]      fsel_i;
  logic [SHIFT_W-1:0]     n_shifts_i;
  logic                   phi_p_o, phi_l1_o, phi_l2_o, phi_r_o;
  logic                   adc_start_o, busy_o, frame_done_o;
  logic [FRAME_CNT_W-1:0] frame_cnt_o;
  logic [2:0]             state_o;

  modport master (
    output tick_i, enable_i, single_i, start_i, fsel_i, n_shifts_i,
    input  phi_p_o, phi_l1_o, phi_l2_o, phi_r_o, adc_start_o, busy_o,
           frame_done_o, frame_cnt_o, state_o
  );

  modport slave (
    input  tick_i, enable_i, single_i, start_i, fsel_i, n_shifts_i,
    output phi_p_o, phi_l1_o, phi_l2_o, phi_r_o, adc_start_o, busy_o,
           frame_done_o, frame_cnt_o, state_o
  );
endinterface

// File: rtl/ccd_frame_sequencer_wave_decode.sv
// Pure decode of (state, phase) to CCD phase levels and the ADC-start condition.
module ccd_wave_decode
  import ccd_seq_pkg::*;
#(
  parameter int CYCLE_LEN = 16,
  parameter int PH_W      = $clog2(CYCLE_LEN)
) (
  input  ccd_state_e      state_i,
  input  logic [PH_W-1:0] ph_i,
  output logic            phi_p_o,
  output logic            phi_l1_o,
  output logic            phi_l2_o,
  output logic            phi_r_o,
  output logic            adc_cond_o
);
  localparam logic [PH_W-1:0] HALF = PH_W'(half_len(CYCLE_LEN));
  localparam logic [PH_W-1:0] TQ   = PH_W'(tq_len(CYCLE_LEN));

  always_comb begin
    phi_p_o    = 1'b0;
    phi_l1_o   = 1'b0;
    phi_l2_o   = 1'b0;
    phi_r_o    = 1'b0;
    adc_cond_o = 1'b0;
    case (state_i)
      ST_SHIFT: begin
        phi_l1_o   = ph_i < HALF;
        phi_l2_o   = ph_i >= HALF;
        phi_r_o    = (ph_i >= HALF) && (ph_i < TQ);
        adc_cond_o = ph_i == HALF;
      end
      ST_SETUP, ST_PULSE: begin
        phi_p_o  = 1'b1;
        phi_l2_o = 1'b1;
        phi_r_o  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/ccd_frame_sequencer.sv
// CCD readout sequencer: tick-enabled FSM generating phase waveforms, ADC
// strobes and frame bookkeeping; every output is registered from next-state.
module ccd_frame_sequencer
  import ccd_seq_pkg::*;
#(
  parameter int          CYCLE_LEN   = 16,
  parameter int          SHIFT_W     = 12,
  parameter int          PHI_P_WIDTH = 4,
  parameter logic [31:0] HOLD_BASE   = HOLD_BASE_DEF,
  parameter logic [31:0] STEP        = STEP_DEF,
  parameter int          FSEL_W      = 4,
  parameter int          FRAME_CNT_W = 16
) (
  input logic                  wb_clk_i,
  input logic                  wb_rst_ni,
  ccd_frame_sequencer_if.slave bus
);
  localparam int PH_W  = $clog2(CYCLE_LEN);
  localparam int DUR_W = 32 + FSEL_W;
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(CYCLE_LEN - 1);
  localparam logic [DUR_W-1:0] PHI_P_LAST = DUR_W'(PHI_P_WIDTH - 1);

  ccd_state_e             state_q, state_d;
  logic [DUR_W-1:0]       dur_q, dur_d, hold_len;
  logic [PH_W-1:0]        ph_q, ph_d;
  logic [SHIFT_W-1:0]     sh_q, sh_d, nsh_q, nsh_d, n_eff;
  logic [FSEL_W-1:0]      fsel_q, fsel_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                   pend_q, pend_d, done_d;
  logic [3:0]             phi_q;
  logic                   adc_q, done_q, busy_q;
  logic                   p_d, l1_d, l2_d, r_d, adc_c;

  assign n_eff    = (bus.n_shifts_i == '0) ? SHIFT_W'(1) : bus.n_shifts_i;
  // Widened before the multiply so the worst-case HOLD never wraps.
  assign hold_len = DUR_W'(HOLD_BASE) + DUR_W'(fsel_q) * DUR_W'(STEP);

  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    ph_d    = ph_q;
    sh_d    = sh_q;
    nsh_d   = nsh_q;
    fsel_d  = fsel_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (!bus.enable_i) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
    end else begin
      if (state_q == ST_IDLE && bus.start_i) pend_d = 1'b1;
      if (bus.tick_i) begin
        case (state_q)
          ST_IDLE: if (pend_q) begin
            state_d = ST_SETUP;
            pend_d  = 1'b0;
            dur_d   = PHI_P_LAST;
            nsh_d   = n_eff;
            fsel_d  = bus.fsel_i;
          end
          ST_SETUP: if (dur_q == '0) begin
            state_d = ST_SHIFT;
            ph_d    = '0;
            sh_d    = '0;
          end else dur_d = dur_q - DUR_W'(1);
          ST_SHIFT: begin
            ph_d = ph_q + PH_W'(1);
            if (ph_q == PH_LAST) begin
              if (sh_q == nsh_q - SHIFT_W'(1)) begin
                state_d = ST_HOLD;
                dur_d   = hold_len - DUR_W'(1);
              end else sh_d = sh_q + SHIFT_W'(1);
            end
          end
          ST_HOLD: if (dur_q == '0) begin
            state_d = ST_PULSE;
            dur_d   = PHI_P_LAST;
          end else dur_d = dur_q - DUR_W'(1);
          ST_PULSE: if (dur_q == '0) begin
            done_d = 1'b1;
            cnt_d  = cnt_q + FRAME_CNT_W'(1);
            if (bus.single_i) state_d = ST_IDLE;
            else begin
              state_d = ST_SHIFT;
              ph_d    = '0;
              sh_d    = '0;
              nsh_d   = n_eff;
              fsel_d  = bus.fsel_i;
            end
          end else dur_d = dur_q - DUR_W'(1);
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  ccd_wave_decode #(.CYCLE_LEN(CYCLE_LEN), .PH_W(PH_W)) u_dec (
    .state_i(state_d), .ph_i(ph_d),
    .phi_p_o(p_d), .phi_l1_o(l1_d), .phi_l2_o(l2_d), .phi_r_o(r_d),
    .adc_cond_o(adc_c)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      dur_q   <= '0;
      ph_q    <= '0;
      sh_q    <= '0;
      nsh_q   <= SHIFT_W'(1);
      fsel_q  <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      phi_q   <= '0;
      adc_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      ph_q    <= ph_d;
      sh_q    <= sh_d;
      nsh_q   <= nsh_d;
      fsel_q  <= fsel_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      phi_q   <= {p_d, l1_d, l2_d, r_d};
      // Strobe only when ph actually steps onto the midpoint, not while parked there.
      adc_q   <= adc_c & (ph_d != ph_q);
      done_q  <= done_d;
      busy_q  <= state_d != ST_IDLE;
    end
  end

  assign {bus.phi_p_o, bus.phi_l1_o, bus.phi_l2_o, bus.phi_r_o} = phi_q;
  assign bus.adc_start_o  = adc_q;
  assign bus.frame_done_o = done_q;
  assign bus.busy_o       = busy_q;
  assign bus.frame_cnt_o  = cnt_q;
  assign bus.state_o      = state_q;
endmodule
